// File: rtl/btb_2bit_predictor.sv
// Direct-mapped branch target buffer with tagged entries and 2-bit
// saturating direction counters. Lookup is combinational from the fetch PC.
// EX trains the table through a single update port. Invalidation is a
// multi-cycle sweep that clears one valid bit per cycle, so the arrays can
// map to RAM.
module btb_2bit_predictor #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned INDEX_W   = 8,
  parameter logic [1:0]  CNT_ALLOC = 2'b10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] _pc,
  output logic              prediction,
  input  logic              br_update,
  input  logic              br,
  input  logic [ADDR_W-1:0] br_address,
  input  logic [ADDR_W-1:0] br_pc,
  output logic              busy
);

  localparam int unsigned TAG_W   = ADDR_W - INDEX_W - 2;
  localparam int unsigned ENTRIES = 2 ** INDEX_W;

  typedef enum logic {
    S_IDLE,
    S_CLEAR
  } state_t;

  state_t             r_state;
  logic [INDEX_W-1:0] r_clr_idx;
  logic               r_busy;

  logic [ENTRIES-1:0] r_valid;
  logic [TAG_W-1:0]   r_tag    [ENTRIES];
  logic [ADDR_W-1:0]  r_target [ENTRIES];
  logic [1:0]         r_cnt    [ENTRIES];

  logic [INDEX_W-1:0] w_l_idx;
  logic [TAG_W-1:0]   w_l_tag;
  logic               w_l_hit;
  logic [ADDR_W-1:0]  w_seq_pc;

  logic [INDEX_W-1:0] w_u_idx;
  logic [TAG_W-1:0]   w_u_tag;
  logic               w_u_hit;
  logic               w_u_en;
  logic [1:0]         w_u_cnt;
  logic [1:0]         w_cnt_inc;
  logic [1:0]         w_cnt_dec;

  // Byte-offset bits never take part in indexing or tagging.
  logic w_unused_lsbs;
  assign w_unused_lsbs = ^{pc[1:0], br_pc[1:0]};

  // Lookup side: index/tag split of the fetch PC and sequential fallback.
  assign w_l_idx  = pc[INDEX_W+1:2];
  assign w_l_tag  = pc[ADDR_W-1:INDEX_W+2];
  assign w_l_hit  = r_valid[w_l_idx] && (r_tag[w_l_idx] == w_l_tag);
  assign w_seq_pc = pc + ADDR_W'(4);

  // Update side: only trains when idle and not held in reset.
  assign w_u_idx   = br_pc[INDEX_W+1:2];
  assign w_u_tag   = br_pc[ADDR_W-1:INDEX_W+2];
  assign w_u_hit   = r_valid[w_u_idx] && (r_tag[w_u_idx] == w_u_tag);
  assign w_u_en    = br_update && !rst && (r_state == S_IDLE);
  assign w_u_cnt   = r_cnt[w_u_idx];
  assign w_cnt_inc = (w_u_cnt == 2'b11) ? 2'b11 : w_u_cnt + 2'd1;
  assign w_cnt_dec = (w_u_cnt == 2'b00) ? 2'b00 : w_u_cnt - 2'd1;

  assign busy = r_busy;

  // Next-PC selection; predictions are suppressed in reset and during the sweep.
  always_comb begin
    _pc        = w_seq_pc;
    prediction = 1'b0;
    if (!rst && !r_busy && w_l_hit && r_cnt[w_l_idx][1]) begin
      _pc        = r_target[w_l_idx];
      prediction = 1'b1;
    end
  end

  // Sweep controller: reset or flush (re)starts the clear from index 0.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_state   <= S_CLEAR;
      r_clr_idx <= '0;
      r_busy    <= 1'b1;
    end else if (r_state == S_CLEAR) begin
      r_clr_idx <= r_clr_idx + INDEX_W'(1);
      if (r_clr_idx == {INDEX_W{1'b1}}) begin
        r_state <= S_IDLE;
        r_busy  <= 1'b0;
      end
    end
  end

  // Valid bits: cleared one per cycle by the sweep, set on allocation.
  always_ff @(posedge clk) begin
    if (!rst && (r_state == S_CLEAR)) begin
      r_valid[r_clr_idx] <= 1'b0;
    end else if (w_u_en && br && !w_u_hit) begin
      r_valid[w_u_idx] <= 1'b1;
    end
  end

  // Entry payload: counter training on hit, full overwrite on taken miss.
  always_ff @(posedge clk) begin
    if (w_u_en) begin
      if (w_u_hit) begin
        if (br) begin
          r_cnt[w_u_idx]    <= w_cnt_inc;
          r_target[w_u_idx] <= br_address;
        end else begin
          r_cnt[w_u_idx] <= w_cnt_dec;
        end
      end else if (br) begin
        r_tag[w_u_idx]    <= w_u_tag;
        r_target[w_u_idx] <= br_address;
        r_cnt[w_u_idx]    <= CNT_ALLOC;
      end
    end
  end

endmodule

// File: doc/btb_2bit_predictor.md
Name: btb_2bit_predictor

Overview:
- Parametrised direct-mapped branch target buffer with 2-bit saturating direction counters, tagged entries and valid bits.
- Sits between pc_reg/IF and EX, in the same position as the current 1-bit predictor.
- Gives IF a next-PC and a taken prediction combinationally from the current PC. EX trains it through a single update port.
- Table invalidation is a multi-cycle sweep FSM, not a single-cycle array clear, so the arrays map to RAM.

Parameters:
- ADDR_W, 32, instruction address width.
- INDEX_W, 8, index bits; entries = 2**INDEX_W; index = pc[INDEX_W+1:2].
- TAG_W, ADDR_W-INDEX_W-2 (derived), tag = pc[ADDR_W-1:INDEX_W+2].
- CNT_ALLOC, 2'b10, counter value written on allocation (weakly taken).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  request full table invalidation (same effect on the table as rst).
- pc  in  ADDR_W  fetch PC from IF.
- _pc  out  ADDR_W  predicted next PC to pc_reg.
- prediction  out  1  1 = predicted taken, to IF/ID.
- br_update  in  1  EX resolved a branch this cycle.
- br  in  1  resolved direction, 1 = taken.
- br_address  in  ADDR_W  resolved target.
- br_pc  in  ADDR_W  PC of the resolved branch.
- busy  out  1  high while the clear sweep runs.

Behaviour:
- Storage per entry: valid (1), tag (TAG_W), target (ADDR_W), cnt (2).
- Lookup is combinational: hit = valid[idx(pc)] && tag[idx(pc)] == tag(pc).
  - hit && cnt[1]: _pc = target, prediction = 1.
  - Otherwise: _pc = pc + 4 (modulo 2**ADDR_W), prediction = 0.
- Forced outputs: during rst, or while busy = 1, lookup forces _pc = pc + 4 and prediction = 0.
- The lookup reads pre-edge contents. An update to the same index in the same cycle becomes visible from the next cycle only.
- FSM states: IDLE and CLEAR, with clr_idx (INDEX_W bits).
  - rst = 1: state <= CLEAR, clr_idx <= 0, busy = 1. Held there while rst stays high. Updates are ignored.
  - CLEAR: each cycle valid[clr_idx] <= 0 and clr_idx <= clr_idx + 1. After clearing index 2**INDEX_W-1, state <= IDLE.
  - busy = (state == CLEAR) and is registered. After rst falls, busy stays high for exactly 2**INDEX_W cycles.
  - flush = 1 in IDLE: enter CLEAR with clr_idx <= 0.
  - flush = 1 in CLEAR: restart at clr_idx <= 0. rst has priority over flush.
  - Target, tag and cnt are never cleared; only valid is cleared.
- Update rules apply only in IDLE with br_update = 1; updates in CLEAR are dropped. With u = idx(br_pc):
  - Hit, br = 1: cnt <= sat_inc(cnt), max 3; target <= br_address.
  - Hit, br = 0: cnt <= sat_dec(cnt), min 0; target unchanged.
  - Miss, br = 1: allocate by overwriting any prior entry. valid <= 1, tag <= tag(br_pc), target <= br_address, cnt <= CNT_ALLOC.
  - Miss, br = 0: no change; not-taken branches never allocate.
- Aliasing: two PCs with the same index and different tags evict each other. A lookup on the non-resident PC is a miss.
- br_pc[1:0] and pc[1:0] are ignored for indexing and tagging.

Test Plan:
- Reset sweep: hold rst 3 cycles, then release. busy = 1 for exactly 256 cycles (INDEX_W = 8), then 0. Throughout, with pc = 0x100, _pc = 0x104 and prediction = 0.
- Allocate and predict: after the sweep, update br_pc = 0x100, br = 1, br_address = 0x200. Next cycle pc = 0x100 gives _pc = 0x200, prediction = 1 (cnt = 2).
- Hysteresis: from cnt = 2, train taken twice (cnt = 3), then not-taken once. pc = 0x100 still predicts 0x200. A second not-taken update gives cnt = 1 and _pc = 0x104, prediction = 0. Saturation check: a further not-taken leaves cnt = 0; three taken updates give 3, and a fourth taken keeps it at 3.
- Alias eviction: entry for 0x100 valid, then taken update br_pc = 0x500 (same index, different tag), target 0x40. pc = 0x100 misses and gives 0x104; pc = 0x500 gives 0x40.
- Not-taken miss: update br_pc = 0x300, br = 0 on an empty table. pc = 0x300 stays a miss with _pc = 0x304. Same-cycle check: update and lookup at 0x100 in one cycle; the lookup shows the old result and the new result appears next cycle.
- Flush mid-sweep: start a flush, and re-assert flush at clr_idx = 100. busy stays high 256 more cycles, and a br_update issued during busy leaves no entry afterwards.
